// File: rtl/safety_obi_mem_responder.sv
// OBI-style SRAM responder: single-cycle accept, fixed-latency response pipeline,
// error responses for misaligned or out-of-range addresses.
module safety_obi_mem_responder #(
  parameter int unsigned NumWords = 1024,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned Latency  = 1,
  parameter logic [31:0] ErrVal   = 32'hBADCAB1E
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_i
);

  localparam int unsigned AW = $clog2(NumWords);

  logic [31:0]   mem [NumWords];

  logic          accept;
  logic [32:0]   offset;
  logic          below;
  logic          above;
  logic          misaligned;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   resp_data;

  logic [Latency-1:0] valid_q;
  logic [Latency-1:0] err_q;
  logic [31:0]        data_q [Latency];

  assign gnt_o  = req_i & ~stall_i & ~rst_i;
  assign accept = gnt_o;

  // Decode on the offset from BaseAddr: the borrow bit flags addresses below
  // the window, and BaseAddr alignment lets the low bits stand in for addr_i.
  always_comb begin
    offset     = {1'b0, addr_i} - {1'b0, BaseAddr};
    below      = offset[32];
    above      = |offset[31:AW+2];
    misaligned = |offset[1:0];
    err        = below | above | misaligned;
    idx        = offset[AW+1:2];
  end

  always_comb begin
    rd_word   = mem[idx];
    resp_data = '0;
    if (err) begin
      resp_data = ErrVal;
    end else if (!we_i) begin
      resp_data = rd_word;
    end
  end

  // Array has no reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && !err) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < Latency; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= accept;
      err_q[0]   <= accept & err;
      data_q[0]  <= accept ? resp_data : '0;
      for (int unsigned i = 1; i < Latency; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Empty slots carry zero data and no error, so idle outputs are already zero.
  assign rvalid_o = valid_q[Latency-1];
  assign err_o    = err_q[Latency-1];
  assign rdata_o  = data_q[Latency-1];

endmodule

// File: tb/tb_safety_obi_mem_responder.sv
// Directed bench: three responders (Latency 1, 3, 4) share one stimulus stream,
// so array contents match across instances and each test watches one of them.
module tb_safety_obi_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        stall;

  logic        gnt1, rvalid1, err1;
  logic [31:0] rdata1;
  logic        gnt3, rvalid3, err3;
  logic [31:0] rdata3;
  logic        gnt4, rvalid4, err4;
  logic [31:0] rdata4;

  int checks   = 0;
  int failures = 0;
  int resp_cnt;

  safety_obi_mem_responder #(.NumWords(16), .BaseAddr(32'h0), .Latency(1), .ErrVal(32'hBADCAB1E)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1), .stall_i(stall));

  safety_obi_mem_responder #(.NumWords(16), .BaseAddr(32'h0), .Latency(3), .ErrVal(32'hBADCAB1E)) u3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt3), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3), .stall_i(stall));

  safety_obi_mem_responder #(.NumWords(16), .BaseAddr(32'h0), .Latency(4), .ErrVal(32'hBADCAB1E)) u4 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt4), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rvalid4), .rdata_o(rdata4), .err_o(err4), .stall_i(stall));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req   = 1'b1;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    req   = 1'b1;
    addr  = '0;
    we    = 1'b0;
    be    = 4'hF;
    wdata = '0;
    stall = 1'b0;

    // Reset state, with req_i high to show grant is masked.
    idle(2);
    chk1("rst_gnt", gnt1, 1'b0);
    chk1("rst_rvalid", rvalid1, 1'b0);
    chk("rst_rdata", rdata1, 32'h0);
    chk1("rst_err", err1, 1'b0);
    chk1("rst_rvalid4", rvalid4, 1'b0);
    rst = 1'b0;
    req = 1'b0;
    idle(1);

    // Fill words 0..7 with 0..7, then stream 8 reads through the Latency=3 instance.
    for (int i = 0; i < 8; i++) issue(1'b1, 32'(i * 4), 4'hF, 32'(i));
    idle(4);
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'(c * 4);
      end else begin
        req = 1'b0;
      end
      @(posedge clk);
      #1;
      chk1("stream_rvalid", rvalid3, (c >= 2 && c <= 9));
      chk("stream_rdata", rdata3, (c >= 2 && c <= 9) ? 32'(c - 2) : 32'h0);
      chk1("stream_err", err3, 1'b0);
    end
    req = 1'b0;
    idle(2);

    // Write then read back-to-back, Latency=1.
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    chk1("wr_rvalid", rvalid1, 1'b1);
    chk("wr_rdata", rdata1, 32'h0);
    chk1("wr_err", err1, 1'b0);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    chk1("rd_rvalid", rvalid1, 1'b1);
    chk("rd_rdata", rdata1, 32'hDEADBEEF);
    idle(1);
    chk1("idle_rvalid", rvalid1, 1'b0);
    chk("idle_rdata", rdata1, 32'h0);

    // Partial write and be=0 write.
    issue(1'b1, 32'h14, 4'hF, 32'h11223344);
    issue(1'b1, 32'h14, 4'b0101, 32'hAABBCCDD);
    issue(1'b0, 32'h14, 4'hF, 32'h0);
    chk("partial_rdata", rdata1, 32'h11BB33DD);
    issue(1'b1, 32'h14, 4'h0, 32'hFFFFFFFF);
    chk1("be0_rvalid", rvalid1, 1'b1);
    chk1("be0_err", err1, 1'b0);
    issue(1'b0, 32'h14, 4'hF, 32'h0);
    chk("be0_rdata", rdata1, 32'h11BB33DD);

    // Error accesses and the last valid word.
    issue(1'b0, 32'h40, 4'hF, 32'h0);
    chk1("oor_rd_err", err1, 1'b1);
    chk("oor_rd_rdata", rdata1, 32'hBADCAB1E);
    issue(1'b1, 32'h2, 4'hF, 32'h12345678);
    chk1("mis_wr_err", err1, 1'b1);
    chk("mis_wr_rdata", rdata1, 32'hBADCAB1E);
    issue(1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
    chk1("oor_wr_err", err1, 1'b1);
    issue(1'b0, 32'h0, 4'hF, 32'h0);
    chk1("word0_err", err1, 1'b0);
    chk("word0_unchanged", rdata1, 32'h0);
    issue(1'b1, 32'h3C, 4'hF, 32'hCAFEF00D);
    chk1("last_wr_err", err1, 1'b0);
    issue(1'b0, 32'h3C, 4'hF, 32'h0);
    chk("last_rdata", rdata1, 32'hCAFEF00D);
    chk1("last_err", err1, 1'b0);
    idle(4);

    // Stall injection: two stalled cycles, then a single accept.
    resp_cnt = 0;
    stall = 1'b1;
    req   = 1'b1;
    we    = 1'b0;
    addr  = 32'h10;
    #1;
    chk1("stall_gnt_c1", gnt1, 1'b0);
    @(posedge clk);
    #1;
    chk1("stall_gnt_c2", gnt1, 1'b0);
    if (rvalid1) resp_cnt++;
    @(posedge clk);
    #1;
    if (rvalid1) resp_cnt++;
    stall = 1'b0;
    #1;
    chk1("stall_gnt_c3", gnt1, 1'b1);
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("stall_rdata", rdata1, 32'hDEADBEEF);
    if (rvalid1) resp_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (rvalid1) resp_cnt++;
    end
    chk("stall_resp_count", 32'(resp_cnt), 32'd1);

    // Mid-flight reset on the Latency=4 instance.
    issue(1'b0, 32'h0, 4'hF, 32'h0);
    issue(1'b0, 32'h4, 4'hF, 32'h0);
    issue(1'b0, 32'h8, 4'hF, 32'h0);
    rst = 1'b1;
    #1;
    chk1("midrst_rvalid_in_rst", rvalid4, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (rvalid4) resp_cnt++;
      @(posedge clk);
      #1;
    end
    chk("midrst_resp_count", 32'(resp_cnt), 32'd0);
    issue(1'b0, 32'h10, 4'hF, 32'h0);
    chk("midrst_persist_l1", rdata1, 32'hDEADBEEF);
    idle(3);
    chk1("midrst_rvalid_l4", rvalid4, 1'b1);
    chk("midrst_persist_l4", rdata4, 32'hDEADBEEF);
    idle(1);
    chk1("midrst_l4_single", rvalid4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
